// File: rtl/mem_wb_pkg.sv
// Shared types for the MEM/WB pipeline register: FSM state encoding and
// occupancy counter width.
package mem_wb_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } wb_state_e;

  localparam int unsigned COUNT_W = 2;

endpackage

// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline stage as a 2-entry skid buffer: head drives the WB outputs
// and the forwarding port, skid absorbs one entry so in_ready can be registered.
module mem_wb_pipe
  import mem_wb_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_W  = 5,
  parameter int QTR_W  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_write,
  input  logic [QTR_W-1:0]   in_quarter,
  input  logic [REG_W-1:0]   in_write_reg,
  input  logic [DATA_W-1:0]  in_write_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_write,
  output logic [QTR_W-1:0]   out_quarter,
  output logic [REG_W-1:0]   out_write_reg,
  output logic [DATA_W-1:0]  out_write_data,
  output logic               fwd_hit,
  output logic [REG_W-1:0]   fwd_reg,
  output logic [DATA_W-1:0]  fwd_data,
  output logic [COUNT_W-1:0] count
);

  typedef struct packed {
    logic              write;
    logic [QTR_W-1:0]  quarter;
    logic [REG_W-1:0]  write_reg;
    logic [DATA_W-1:0] write_data;
  } payload_t;

  wb_state_e state_q, state_d;
  payload_t  head_q, head_d;
  payload_t  skid_q, skid_d;
  logic      in_ready_q, in_ready_d;
  payload_t  in_entry;
  logic      in_fire, out_fire;

  assign in_entry = '{write:      in_write,
                      quarter:    in_quarter,
                      write_reg:  in_write_reg,
                      write_data: in_write_data};

  assign in_fire  = in_valid && in_ready_q;
  assign out_fire = (state_q != EMPTY) && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b0;
      head_q     <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
    end
  end

  // Flush only clears the occupancy; payload registers keep their contents.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            head_d  = in_entry;
            state_d = ONE;
          end
        end
        ONE: begin
          if (in_fire && !out_fire) begin
            skid_d  = in_entry;
            state_d = FULL;
          end else if (in_fire && out_fire) begin
            head_d  = in_entry;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            head_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    in_ready_d = (state_d != FULL);
  end

  always_comb begin
    out_valid      = (state_q != EMPTY);
    in_ready       = in_ready_q;
    out_write      = head_q.write;
    out_quarter    = head_q.quarter;
    out_write_reg  = head_q.write_reg;
    out_write_data = head_q.write_data;
    fwd_hit        = out_valid && head_q.write && (head_q.write_reg != '0);
    fwd_reg        = fwd_hit ? head_q.write_reg  : '0;
    fwd_data       = fwd_hit ? head_q.write_data : '0;
    count          = '0;
    unique case (state_q)
      ONE:     count = COUNT_W'(1);
      FULL:    count = COUNT_W'(2);
      default: count = '0;
    endcase
  end

endmodule
